// File: rtl/run_monitor.sv
// Run supervisor for the nlp16af core: launches a run, counts RUN cycles,
// filters the core finish flag and captures result/cycle count or a timeout.
module run_monitor #(
  parameter int DATA_W   = 16,
  parameter int CNT_W    = 32,
  parameter int TIMEOUT  = 1000,
  parameter int FIN_HOLD = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_finish,
  input  logic [DATA_W-1:0] i_result_data,
  input  logic              i_ack,
  output logic              o_busy,
  output logic              o_valid,
  output logic              o_timeout,
  output logic [DATA_W-1:0] o_result,
  output logic [CNT_W-1:0]  o_cycles,
  output logic              o_core_rst,
  output logic [1:0]        o_state
);

  // Result handshake: o_valid rises with DONE/TOUT and holds with stable
  // o_result/o_cycles until i_ack is sampled high; the transfer happens on
  // that edge and o_valid drops in the following cycle.

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_TOUT = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W:0]   TIMEOUT_W = (CNT_W+1)'(TIMEOUT);
  localparam logic [3:0]       HOLD_LAST = 4'(FIN_HOLD - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] cyc_next;
  logic [CNT_W:0]   cyc_inc;
  logic [3:0]       hold_cnt;
  logic             qualify;
  logic             timeout_hit;

  // The unsaturated increment is one bit wider so the timeout compare never
  // aliases when the counter sits at its maximum.
  always_comb begin
    cyc_inc     = {1'b0, cyc_cnt} + (CNT_W+1)'(1);
    cyc_next    = (cyc_cnt == CNT_MAX) ? cyc_cnt : cyc_inc[CNT_W-1:0];
    qualify     = i_finish && (hold_cnt == HOLD_LAST);
    timeout_hit = (TIMEOUT != 0) && (cyc_inc == TIMEOUT_W);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= S_IDLE;
      cyc_cnt  <= '0;
      hold_cnt <= '0;
      o_result <= '0;
      o_cycles <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cyc_cnt  <= '0;
          hold_cnt <= '0;
          if (i_start) state <= S_RUN;
        end
        S_RUN: begin
          cyc_cnt <= cyc_next;
          if (!i_finish)              hold_cnt <= '0;
          else if (hold_cnt != 4'hF)  hold_cnt <= hold_cnt + 4'd1;
          // A qualifying finish beats a coincident timeout.
          if (qualify) begin
            state    <= S_DONE;
            o_result <= i_result_data;
            o_cycles <= cyc_next;
          end else if (timeout_hit) begin
            state    <= S_TOUT;
            o_result <= '0;
            o_cycles <= TIMEOUT_W[CNT_W-1:0];
          end
        end
        S_DONE, S_TOUT: begin
          if (i_ack) begin
            state    <= S_IDLE;
            o_result <= '0;
            o_cycles <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_busy     = (state == S_RUN);
  assign o_valid    = (state == S_DONE) || (state == S_TOUT);
  assign o_timeout  = (state == S_TOUT);
  assign o_core_rst = (state == S_IDLE);
  assign o_state    = state;

endmodule

// File: tb/tb_run_monitor.sv
// Directed bench for run_monitor: four parameterisations share one stimulus
// stream; each step checks the instance it targets.
module tb_run_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        finish;
  logic [15:0] data;
  logic        ack;

  int checks = 0;
  int errors = 0;

  // defaults
  logic        d_busy, d_valid, d_tout, d_crst;
  logic [15:0] d_res;
  logic [31:0] d_cyc;
  logic [1:0]  d_st;
  // FIN_HOLD=3
  logic        h_busy, h_valid, h_tout, h_crst;
  logic [15:0] h_res;
  logic [31:0] h_cyc;
  logic [1:0]  h_st;
  // TIMEOUT=8
  logic        t_busy, t_valid, t_tout, t_crst;
  logic [15:0] t_res;
  logic [31:0] t_cyc;
  logic [1:0]  t_st;
  // TIMEOUT=0, CNT_W=4
  logic        s_busy, s_valid, s_tout, s_crst;
  logic [15:0] s_res;
  logic [3:0]  s_cyc;
  logic [1:0]  s_st;

  always #5 clk = ~clk;

  run_monitor u_def (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_finish(finish),
    .i_result_data(data), .i_ack(ack), .o_busy(d_busy), .o_valid(d_valid),
    .o_timeout(d_tout), .o_result(d_res), .o_cycles(d_cyc),
    .o_core_rst(d_crst), .o_state(d_st)
  );

  run_monitor #(.FIN_HOLD(3)) u_fh3 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_finish(finish),
    .i_result_data(data), .i_ack(ack), .o_busy(h_busy), .o_valid(h_valid),
    .o_timeout(h_tout), .o_result(h_res), .o_cycles(h_cyc),
    .o_core_rst(h_crst), .o_state(h_st)
  );

  run_monitor #(.TIMEOUT(8)) u_to8 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_finish(finish),
    .i_result_data(data), .i_ack(ack), .o_busy(t_busy), .o_valid(t_valid),
    .o_timeout(t_tout), .o_result(t_res), .o_cycles(t_cyc),
    .o_core_rst(t_crst), .o_state(t_st)
  );

  run_monitor #(.TIMEOUT(0), .CNT_W(4)) u_sat (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_finish(finish),
    .i_result_data(data), .i_ack(ack), .o_busy(s_busy), .o_valid(s_valid),
    .o_timeout(s_tout), .o_result(s_res), .o_cycles(s_cyc),
    .o_core_rst(s_crst), .o_state(s_st)
  );

  // Advance past one rising edge; inputs are driven and outputs sampled 1ns later.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; finish = 1'b0; ack = 1'b0; data = '0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; finish = 1'b0; ack = 1'b0; data = '0;

    // Reset values
    do_reset();
    check("rst_busy",  {31'b0, d_busy},  32'd0);
    check("rst_valid", {31'b0, d_valid}, 32'd0);
    check("rst_tout",  {31'b0, d_tout},  32'd0);
    check("rst_res",   {16'b0, d_res},   32'd0);
    check("rst_cyc",   d_cyc,            32'd0);
    check("rst_crst",  {31'b0, d_crst},  32'd1);

    // Defaults: finish in RUN cycle 37
    pulse_start();
    check("run_busy", {31'b0, d_busy}, 32'd1);
    check("run_crst", {31'b0, d_crst}, 32'd0);
    tick(36);
    finish = 1'b1; data = 16'h1234;
    tick();
    finish = 1'b0; data = 16'h0;
    check("fin_valid", {31'b0, d_valid}, 32'd1);
    check("fin_busy",  {31'b0, d_busy},  32'd0);
    check("fin_tout",  {31'b0, d_tout},  32'd0);
    check("fin_res",   {16'b0, d_res},   32'h1234);
    check("fin_cyc",   d_cyc,            32'd37);

    // Start during DONE is ignored
    pulse_start();
    check("done_start_st",  {30'b0, d_st},   32'd2);
    check("done_start_res", {16'b0, d_res},  32'h1234);
    check("done_start_cyc", d_cyc,           32'd37);

    // Start and ack together: ack wins, no run begins
    start = 1'b1; ack = 1'b1;
    tick();
    start = 1'b0; ack = 1'b0;
    check("ack_valid", {31'b0, d_valid}, 32'd0);
    check("ack_busy",  {31'b0, d_busy},  32'd0);
    check("ack_res",   {16'b0, d_res},   32'd0);
    check("ack_cyc",   d_cyc,            32'd0);
    check("ack_crst",  {31'b0, d_crst},  32'd1);
    tick();
    check("ack_stay_idle", {30'b0, d_st}, 32'd0);

    // Defaults: timeout after 1000 RUN cycles
    do_reset();
    pulse_start();
    tick(999);
    check("to_pre_busy",  {31'b0, d_busy},  32'd1);
    check("to_pre_valid", {31'b0, d_valid}, 32'd0);
    tick();
    check("to_tout",  {31'b0, d_tout},  32'd1);
    check("to_valid", {31'b0, d_valid}, 32'd1);
    check("to_busy",  {31'b0, d_busy},  32'd0);
    check("to_cyc",   d_cyc,            32'd1000);
    check("to_res",   {16'b0, d_res},   32'd0);
    tick(3);
    check("to_hold_cyc", d_cyc, 32'd1000);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("to_ack_tout", {31'b0, d_tout}, 32'd0);
    check("to_ack_cyc",  d_cyc,           32'd0);

    // FIN_HOLD=3: pattern 1,1,0,1,1,1 from RUN cycle 10
    do_reset();
    pulse_start();
    tick(9);
    finish = 1'b1; data = 16'h00AA; tick();
    finish = 1'b1; tick();
    finish = 1'b0; tick();
    check("fh_glitch_busy", {31'b0, h_busy}, 32'd1);
    finish = 1'b1; tick();
    finish = 1'b1; tick();
    check("fh_pre_busy", {31'b0, h_busy}, 32'd1);
    finish = 1'b1; data = 16'h5A5A; tick();
    finish = 1'b0; data = 16'h0;
    check("fh_valid", {31'b0, h_valid}, 32'd1);
    check("fh_cyc",   h_cyc,            32'd15);
    check("fh_res",   {16'b0, h_res},   32'h5A5A);

    // TIMEOUT=8: finish exactly in the timeout cycle wins
    do_reset();
    pulse_start();
    tick(7);
    finish = 1'b1; data = 16'hBEEF;
    tick();
    finish = 1'b0; data = 16'h0;
    check("t8_valid", {31'b0, t_valid}, 32'd1);
    check("t8_tout",  {31'b0, t_tout},  32'd0);
    check("t8_res",   {16'b0, t_res},   32'hBEEF);
    check("t8_cyc",   t_cyc,            32'd8);

    // TIMEOUT=8 with no finish
    do_reset();
    pulse_start();
    tick(8);
    check("t8n_tout", {31'b0, t_tout}, 32'd1);
    check("t8n_cyc",  t_cyc,           32'd8);
    check("t8n_res",  {16'b0, t_res},  32'd0);

    // TIMEOUT=0, CNT_W=4: counter saturates, no timeout
    do_reset();
    pulse_start();
    tick(20);
    check("sat_busy", {31'b0, s_busy}, 32'd1);
    check("sat_tout", {31'b0, s_tout}, 32'd0);
    finish = 1'b1; data = 16'h0F0F;
    tick();
    finish = 1'b0; data = 16'h0;
    check("sat_valid", {31'b0, s_valid}, 32'd1);
    check("sat_cyc",   {28'b0, s_cyc},   32'd15);
    check("sat_res",   {16'b0, s_res},   32'h0F0F);

    // Reset in RUN cycle 5 aborts the run
    do_reset();
    pulse_start();
    tick(4);
    rst = 1'b1; start = 1'b1; ack = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0; ack = 1'b0;
    check("mrst_st",    {30'b0, d_st},   32'd0);
    check("mrst_busy",  {31'b0, d_busy}, 32'd0);
    check("mrst_valid", {31'b0, d_valid},32'd0);
    check("mrst_crst",  {31'b0, d_crst}, 32'd1);
    check("mrst_cyc",   d_cyc,           32'd0);
    check("mrst_res",   {16'b0, d_res},  32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/run_monitor.md
# run_monitor

Synthesizable run supervisor for the nlp16af core: starts a run, counts clock cycles, and waits for the core's finish flag. It captures the result word and cycle count, and flags a timeout if the core never finishes. It sits between the core (o_finish / o_result_data) and the host or bench, and replaces the bench-only watchdog and cycle counter with parametrised RTL. Compared with that bench logic, it adds a finish-hold filter, a configurable or disabled timeout, saturating counting, and a valid/ack result handshake.

## Interface
- DATA_W, 16, width of the captured result word
- CNT_W, 32, width of the cycle counter
- TIMEOUT, 1000, RUN cycles before timeout; 0 disables the timeout
- FIN_HOLD, 1, consecutive cycles i_finish must be high to count as a finish; legal range is 1..15
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_start  in  1  single-cycle start request; honoured only in IDLE
- i_finish  in  1  core finish flag
- i_result_data  in  DATA_W  core result word
- i_ack  in  1  host accepts the captured result
- o_busy  out  1  high while in RUN
- o_valid  out  1  high in DONE or TOUT
- o_timeout  out  1  high in TOUT
- o_result  out  DATA_W  captured result word; 0 on timeout
- o_cycles  out  CNT_W  cycles spent in RUN
- o_core_rst  out  1  active-high reset request to the core; high in IDLE, low in RUN/DONE/TOUT

## Operation
- States: IDLE, RUN, DONE, TOUT. Encoding is free.
- IDLE:
  - i_start=1 moves to RUN.
  - cyc_cnt and hold_cnt clear to 0.
- RUN:
  - cyc_cnt increments every cycle and saturates at 2^CNT_W-1 (no wrap).
  - hold_cnt increments while i_finish=1 and clears to 0 when i_finish=0.
  - Finish qualifies in the cycle where i_finish=1 and hold_cnt==FIN_HOLD-1.
  - On qualify: go to DONE; o_result <= i_result_data from that same cycle; o_cycles <= cyc_cnt+1 (saturated).
  - Timeout: when TIMEOUT!=0, cyc_cnt+1==TIMEOUT, and finish does not qualify in that cycle, go to TOUT with o_result <= 0 and o_cycles <= TIMEOUT.
  - If finish qualifies in the timeout cycle, finish wins and the state goes to DONE.
- DONE / TOUT:
  - Outputs are held stable.
  - i_ack=1 returns to IDLE and clears o_result and o_cycles.
- i_start outside IDLE is ignored; no queuing.
- i_ack outside DONE/TOUT is ignored.
- i_start and i_ack both high in DONE/TOUT: ack is taken and start is dropped. A new start needs a fresh pulse in IDLE.

## Timing
- Reset (i_rst=1 at an edge) moves to IDLE in the next cycle. Reset values:
  - o_busy=0, o_valid=0, o_timeout=0, o_result=0, o_cycles=0, o_core_rst=1.
  - Internal counters are 0.
- Reset mid-run aborts the run with no valid result. Reset overrides start and ack.
- i_start seen at edge N: o_busy=1 and o_core_rst=0 from cycle N+1.
- Finish qualified at edge M: from cycle M+1, o_valid=1, o_busy=0, and o_result/o_cycles are valid. Latency is one cycle.
- o_cycles counts RUN cycles up to and including the qualify cycle. Example: with FIN_HOLD=1, i_finish high in the 5th RUN cycle gives o_cycles=5.
- i_ack at edge K: o_valid=0 and outputs are cleared from cycle K+1. The earliest restart is i_start at edge K+1.
- A glitch shorter than FIN_HOLD cycles does not qualify. hold_cnt restarts from 0 after any low cycle.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Defaults: start, then i_finish=1 with i_result_data=16'h1234 in RUN cycle 37 → o_valid=1, o_result=16'h1234, o_cycles=37, o_timeout=0; ack → all outputs 0, o_core_rst=1.
- TIMEOUT=1000, i_finish held 0 → o_timeout=1 and o_valid=1 one cycle after RUN cycle 1000, with o_cycles=1000 and o_result=0.
- FIN_HOLD=3: i_finish pattern 1,1,0,1,1,1 starting at RUN cycle 10 → qualifies at cycle 15 with o_cycles=15; the 2-cycle pulse is ignored.
- TIMEOUT=8: i_finish=1 first at RUN cycle 8 with data 16'hBEEF → DONE (not TOUT), o_result=16'hBEEF, o_cycles=8.
- TIMEOUT=0, CNT_W=4: no finish for 20 cycles → still RUN; then finish → o_cycles=15 (saturated).
- Reset mid-RUN at cycle 5 → next cycle IDLE with all outputs at reset values; an i_start pulse during DONE is ignored; a simultaneous start and ack in DONE goes to IDLE, not RUN.
